// File: rtl/signal_period_meter.sv
// signal_period_meter
//   Measures the period and the high time of a slow square wave (divider
//   output or probe comparator) in system-clock cycles. sig_in is
//   synchronised into clk. A rising edge starts a measurement. Each later
//   rising edge closes one sample and opens the next one.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   sig_in      measured signal, asynchronous to clk
//   meas_en     1 = measure, 0 = abort and idle
//   period_cnt  cycles between the last two rising edges (saturating)
//   high_cnt    cycles the signal was high within that period
//   valid       one-cycle pulse when period_cnt/high_cnt are updated
//   no_signal   sticky flag: no rising edge for TIMEOUT cycles;
//               cleared by the next valid sample
module signal_period_meter #(
    parameter int CNT_WIDTH   = 24,
    parameter int TIMEOUT     = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sig_in,
    input  logic                 meas_en,
    output logic [CNT_WIDTH-1:0] period_cnt,
    output logic [CNT_WIDTH-1:0] high_cnt,
    output logic                 valid,
    output logic                 no_signal
);

    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]      TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_s, sig_d;
    logic                   rise, fall;

    logic [CNT_WIDTH-1:0]   cnt, high_lat;
    logic [TO_W-1:0]        to_cnt;

    // Control strobes decoded from the FSM state
    logic active;     // ARM or MEASURE with measuring enabled
    logic start;      // first rise after arming: open a measurement
    logic capture;    // rise while measuring: close the sample, open the next one
    logic run;        // advance the cycle counter
    logic mark_fall;  // latch the high time
    logic expire;     // timeout reached with no rise this cycle
    logic to_clear;   // restart the timeout window

    // Input synchroniser and edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            sig_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d  <= sig_s;
        end
    end

    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_d;
    assign fall  = ~sig_s & sig_d;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state. Dropping meas_en wins over everything else.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (meas_en) state_nxt = ARM;
            ARM:     if (!meas_en)   state_nxt = IDLE;
                     else if (rise)  state_nxt = MEASURE;
            MEASURE: if (!meas_en)   state_nxt = IDLE;
                     else if (rise)  state_nxt = MEASURE;
                     else if (expire) state_nxt = ARM;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: output strobes
    always_comb begin
        active    = 1'b0;
        start     = 1'b0;
        capture   = 1'b0;
        run       = 1'b0;
        mark_fall = 1'b0;
        expire    = 1'b0;
        to_clear  = 1'b0;
        case (state)
            IDLE: to_clear = meas_en;
            ARM: begin
                active = meas_en;
                start  = meas_en & rise;
            end
            MEASURE: begin
                active    = meas_en;
                capture   = meas_en & rise;
                run       = meas_en;
                mark_fall = meas_en & fall;
            end
            default: ;
        endcase
        // A rise in the final timeout cycle still counts as signal present.
        expire   = active & ~rise & (to_cnt == TO_LAST);
        to_clear = to_clear | (active & rise) | expire;
    end

    // Timeout window counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        to_cnt <= '0;
        else if (to_clear) to_cnt <= '0;
        else if (active)   to_cnt <= to_cnt + TO_W'(1);
    end

    // Cycle counter and high-time latch. A rise both ends the previous
    // period and begins the next one, so cnt restarts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            high_lat <= '0;
        end else begin
            if (start || capture)         cnt <= CNT_ONE;
            else if (run && cnt != CNT_MAX) cnt <= cnt + CNT_ONE;

            if (start || capture) high_lat <= '0;
            else if (mark_fall)   high_lat <= cnt;
        end
    end

    // Result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            valid      <= 1'b0;
            no_signal  <= 1'b0;
        end else begin
            valid <= capture;
            if (capture) begin
                period_cnt <= cnt;
                high_cnt   <= high_lat;
                no_signal  <= 1'b0;
            end else if (expire) begin
                no_signal  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_signal_period_meter.sv
module tb_signal_period_meter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic sig_in = 1'b0;
    logic meas_en = 1'b0;

    logic [23:0] period_a, high_a;
    logic [23:0] period_b, high_b;
    logic [7:0]  period_c, high_c;
    logic        valid_a, valid_b, valid_c;
    logic        nosig_a, nosig_b, nosig_c;

    int checks = 0;
    int errors = 0;

    // Wave generator control
    bit wave_on = 1'b0;
    int w_per = 4;
    int w_high = 2;
    int phase = 0;

    int vcnt_a = 0, vcnt_b = 0, vcnt_c = 0;
    logic [2:0] vld_vec;
    assign vld_vec = {valid_c, valid_b, valid_a};

    always #5 clk = ~clk;

    signal_period_meter #(.CNT_WIDTH(24), .TIMEOUT(5000), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .meas_en(meas_en),
        .period_cnt(period_a), .high_cnt(high_a), .valid(valid_a), .no_signal(nosig_a));

    signal_period_meter #(.CNT_WIDTH(24), .TIMEOUT(100), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .meas_en(meas_en),
        .period_cnt(period_b), .high_cnt(high_b), .valid(valid_b), .no_signal(nosig_b));

    signal_period_meter #(.CNT_WIDTH(8), .TIMEOUT(1000), .SYNC_STAGES(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .meas_en(meas_en),
        .period_cnt(period_c), .high_cnt(high_c), .valid(valid_c), .no_signal(nosig_c));

    // Valid pulse counters, sampled on the falling edge
    always @(negedge clk) begin
        if (valid_a) vcnt_a <= vcnt_a + 1;
        if (valid_b) vcnt_b <= vcnt_b + 1;
        if (valid_c) vcnt_c <= vcnt_c + 1;
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Returns the number of falling edges until valid of instance 'which', or -1
    task automatic wait_valid(input int which, input int max_cyc, output int lat);
        lat = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (vld_vec[which]) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic start_wave(input int per, input int hi);
        w_per = per;
        w_high = hi;
        wave_on = 1'b1;
    endtask

    task automatic stop_all();
        meas_en = 1'b0;
        wave_on = 1'b0;
        wait_cycles(6);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        wait_cycles(3);
        checks++;
        if (period_a !== 24'd0 || high_a !== 24'd0) begin
            errors++; $display("FAIL reset_a_counts: period=%0d high=%0d, need 0/0", period_a, high_a);
        end
        checks++;
        if (valid_a !== 1'b0 || nosig_a !== 1'b0) begin
            errors++; $display("FAIL reset_a_flags: valid=%b no_signal=%b, need 0/0", valid_a, nosig_a);
        end
        checks++;
        if (period_c !== 8'd0 || high_c !== 8'd0 || valid_c !== 1'b0 || nosig_c !== 1'b0) begin
            errors++; $display("FAIL reset_c: period=%0d high=%0d valid=%b nosig=%b, need all 0",
                               period_c, high_c, valid_c, nosig_c);
        end
        rst_n = 1'b1;
        wait_cycles(2);
    endtask

    task automatic test_divided_clock();
        int lat;
        start_wave(4, 2);
        wait_cycles(3);
        meas_en = 1'b1;
        wait_valid(0, 30, lat);
        checks++;
        if (lat < 0) begin
            errors++; $display("FAIL div_first_valid: none within 30 cycles, need a valid");
        end
        checks++;
        if (period_a !== 24'd4 || high_a !== 24'd2) begin
            errors++; $display("FAIL div_values: period=%0d high=%0d, need 4/2", period_a, high_a);
        end
        for (int k = 0; k < 2; k++) begin
            wait_valid(0, 10, lat);
            checks++;
            if (lat !== 4 || period_a !== 24'd4 || high_a !== 24'd2) begin
                errors++; $display("FAIL div_b2b_%0d: spacing=%0d period=%0d high=%0d, need 4/4/2",
                                   k, lat, period_a, high_a);
            end
        end
        stop_all();
    endtask

    task automatic test_long_period();
        int lat;
        start_wave(1000, 250);
        wait_cycles(3);
        meas_en = 1'b1;
        wait_valid(0, 2500, lat);
        checks++;
        if (lat < 0 || period_a !== 24'd1000 || high_a !== 24'd250) begin
            errors++; $display("FAIL long_first: lat=%0d period=%0d high=%0d, need 1000/250",
                               lat, period_a, high_a);
        end
        wait_valid(0, 1010, lat);
        checks++;
        if (lat !== 1000 || period_a !== 24'd1000 || high_a !== 24'd250) begin
            errors++; $display("FAIL long_second: spacing=%0d period=%0d high=%0d, need 1000/1000/250",
                               lat, period_a, high_a);
        end
        stop_all();
    endtask

    task automatic test_timeout();
        int lat;
        int v0;
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(4);
        v0 = vcnt_b;
        meas_en = 1'b1;
        wait_cycles(50);
        checks++;
        if (nosig_b !== 1'b0) begin
            errors++; $display("FAIL timeout_early: no_signal=%b at 50 cycles, need 0", nosig_b);
        end
        lat = -1;
        for (int i = 51; i <= 150; i++) begin
            @(negedge clk);
            if (nosig_b === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat < 100 || lat > 102) begin
            errors++; $display("FAIL timeout_time: no_signal after %0d cycles, need about 101", lat);
        end
        checks++;
        if (vcnt_b != v0) begin
            errors++; $display("FAIL timeout_no_valid: %0d valids seen, need 0", vcnt_b - v0);
        end
        start_wave(20, 10);
        wait_valid(1, 80, lat);
        checks++;
        if (lat < 0 || nosig_b !== 1'b0 || period_b !== 24'd20 || high_b !== 24'd10) begin
            errors++; $display("FAIL timeout_recover: lat=%0d no_signal=%b period=%0d high=%0d, need 0/20/10",
                               lat, nosig_b, period_b, high_b);
        end
        stop_all();
    endtask

    task automatic test_abort();
        int lat;
        int v0;
        start_wave(20, 10);
        wait_cycles(3);
        meas_en = 1'b1;
        wait_valid(0, 80, lat);
        wait_cycles(5);
        meas_en = 1'b0;
        v0 = vcnt_a;
        wait_cycles(30);
        checks++;
        if (vcnt_a != v0) begin
            errors++; $display("FAIL abort_no_valid: %0d valids while disabled, need 0", vcnt_a - v0);
        end
        meas_en = 1'b1;
        wait_valid(0, 80, lat);
        checks++;
        if (lat < 20 || lat > 45) begin
            errors++; $display("FAIL abort_rearm_latency: %0d cycles, need 20..45", lat);
        end
        checks++;
        if (period_a !== 24'd20 || high_a !== 24'd10) begin
            errors++; $display("FAIL abort_values: period=%0d high=%0d, need 20/10", period_a, high_a);
        end
        stop_all();
    endtask

    task automatic test_saturation();
        int lat;
        start_wave(400, 200);
        wait_cycles(3);
        meas_en = 1'b1;
        wait_valid(2, 1000, lat);
        checks++;
        if (lat < 0 || period_c !== 8'd255 || high_c !== 8'd200) begin
            errors++; $display("FAIL saturate: lat=%0d period=%0d high=%0d, need 255/200",
                               lat, period_c, high_c);
        end
        stop_all();
    endtask

    task automatic test_reset_mid_measure();
        int lat;
        start_wave(20, 10);
        wait_cycles(3);
        meas_en = 1'b1;
        wait_valid(0, 80, lat);
        wait_cycles(5);
        rst_n = 1'b0;
        #1;
        checks++;
        if (period_a !== 24'd0 || high_a !== 24'd0 || valid_a !== 1'b0 || nosig_a !== 1'b0) begin
            errors++; $display("FAIL midreset: period=%0d high=%0d valid=%b nosig=%b, need all 0",
                               period_a, high_a, valid_a, nosig_a);
        end
        wait_cycles(2);
        rst_n = 1'b1;
        wait_valid(0, 80, lat);
        checks++;
        if (lat < 0 || period_a !== 24'd20 || high_a !== 24'd10) begin
            errors++; $display("FAIL midreset_resume: lat=%0d period=%0d high=%0d, need 20/10",
                               lat, period_a, high_a);
        end
        stop_all();
    endtask

    // Square-wave source: changes on the falling edge, one clk per step
    initial begin
        forever begin
            @(negedge clk);
            if (wave_on) begin
                sig_in = (phase < w_high);
                phase = (phase + 1 >= w_per) ? 0 : phase + 1;
            end else begin
                sig_in = 1'b0;
                phase = 0;
            end
        end
    end

    initial begin
        test_reset();
        test_divided_clock();
        test_long_period();
        test_timeout();
        test_abort();
        test_saturation();
        test_reset_mid_measure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
